instr_encoder_writer: RTL and testbench

//  Encoder side of the main control decoder's opcode map. It accepts instruction fields through
//  a valid/ready handshake and encodes each one into a 32-bit instruction word. Each word is

---
 rtl/instr_encoder_writer_if.sv | 38 +++
 rtl/instr_encoder_writer.sv | 136 +++++++++++++
 tb/tb_instr_encoder_writer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_writer_if.sv
// Purpose: bundles the instruction-field handshake and the instruction-memory
//          write bus that belong to instr_encoder_writer.
// Signals:
//   in_valid/in_ready          field handshake (ready driven by the encoder)
//   op_sel, rs, rt, rd, shamt,
//   funct, imm, target         instruction fields offered by the producer
//   mem_we, mem_addr,
//   mem_wdata                  one-cycle write strobe, word address, encoded word
// Modports:
//   master  producer of fields / observer of the memory bus (e.g. a loader or bench)
//   slave   the encoder itself
interface instr_encoder_writer_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        op_sel;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder_writer.sv
// Purpose: accepts instruction fields over a valid/ready handshake, encodes
//          them into 32-bit words using the control decoder's opcode map and
//          writes the words to sequential instruction-memory addresses starting
//          at BASE_ADDR. Used to load test programs into the single-cycle core.
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   clear        synchronous soft restart, same effect as reset
//   bus          field handshake and memory write bus (slave side)
//   count        words written since reset/clear (ADDR_W+1 bits)
//   full         count has reached 2**ADDR_W; further writes are blocked
//   err_invalid  sticky: an invalid op_sel was accepted
//   err_full     sticky: in_valid was presented while full
module instr_encoder_writer #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   instr_encoder_writer_if.slave  bus,
   output logic [ADDR_W:0]        count,
   output logic                   full,
   output logic                   err_invalid,
   output logic                   err_full
);

   typedef enum logic {IDLE, WRITE} state_t;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_BNE  = 6'b100000;
   localparam logic [5:0] OPC_ADDI = 6'b000001;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_JR   = 6'b000011;
   localparam logic [5:0] OPC_JAL  = 6'b000111;
   localparam logic [5:0] OPC_JALR = 6'b001111;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       word_q, word_d;
   logic              err_invalid_q, err_invalid_d;
   logic              err_full_q, err_full_d;

   logic [31:0]       enc_word;
   logic              enc_ok;
   logic              full_w;

   // count never exceeds 2**ADDR_W, so its MSB alone marks the full state.
   assign full_w = count_q[ADDR_W];

   // Opcode map. Each format only concatenates the fields it owns, so
   // unused inputs cannot leak into the emitted word.
   always_comb begin
      enc_word = '0;
      enc_ok   = 1'b1;
      case (bus.op_sel)
         4'd0:    enc_word = {OPC_R, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
         4'd1:    enc_word = {OPC_LW, bus.rs, bus.rt, bus.imm};
         4'd2:    enc_word = {OPC_SW, bus.rs, bus.rt, bus.imm};
         4'd3:    enc_word = {OPC_BEQ, bus.rs, bus.rt, bus.imm};
         4'd4:    enc_word = {OPC_BNE, bus.rs, bus.rt, bus.imm};
         4'd5:    enc_word = {OPC_ADDI, bus.rs, bus.rt, bus.imm};
         4'd6:    enc_word = {OPC_J, bus.target};
         4'd7:    enc_word = {OPC_JR, bus.rs, 21'b0};
         4'd8:    enc_word = {OPC_JAL, bus.target};
         4'd9:    enc_word = {OPC_JALR, bus.rs, 21'b0};
         default: enc_ok   = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      count_d       = count_q;
      word_d        = word_q;
      err_invalid_d = err_invalid_q;
      err_full_d    = err_full_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && full_w) begin
               err_full_d = 1'b1;
            end else if (bus.in_valid) begin
               if (enc_ok) begin
                  word_d  = enc_word;
                  state_d = WRITE;
               end else begin
                  err_invalid_d = 1'b1;
               end
            end
         end
         WRITE: begin
            // The write completes at the end of this cycle; addr wraps naturally.
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + CNT_ONE;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // clear shares the reset path, which also drops a write in flight.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q       <= IDLE;
         addr_q        <= BASE_ADDR;
         count_q       <= '0;
         word_q        <= '0;
         err_invalid_q <= 1'b0;
         err_full_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         count_q       <= count_d;
         word_q        <= word_d;
         err_invalid_q <= err_invalid_d;
         err_full_q    <= err_full_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !full_w;
   assign bus.mem_we    = (state_q == WRITE);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = word_q;
   assign count         = count_q;
   assign full          = full_w;
   assign err_invalid   = err_invalid_q;
   assign err_full      = err_full_q;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Testbench for instr_encoder_writer: small memory (ADDR_W=3) with a non-zero
// base address so fill, wrap and full behaviour are reached quickly. Expected
// values come from a reference model built from the opcode table and simple
// counting of accepted words.
module tb_instr_encoder_writer;
   localparam int                ADDR_W = 3;
   localparam int                CAP    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] BASE   = 3'd6;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } fields_t;

   typedef struct packed {
      logic              ready;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic              we_after;
      logic [ADDR_W:0]   cnt;
      logic              full;
      logic              einv;
      logic              efull;
   } obs_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              clear = 1'b0;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err_invalid;
   logic              err_full;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int   m_count = 0;
   logic m_einv  = 1'b0;
   logic m_efull = 1'b0;

   instr_encoder_writer_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .bus         (bus),
      .count       (count),
      .full        (full),
      .err_invalid (err_invalid),
      .err_full    (err_full)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_word(input fields_t f);
      case (f.op)
         4'd0: return {6'b000000, f.rs, f.rt, f.rd, f.shamt, f.funct};
         4'd1: return {6'b100011, f.rs, f.rt, f.imm};
         4'd2: return {6'b101011, f.rs, f.rt, f.imm};
         4'd3: return {6'b000100, f.rs, f.rt, f.imm};
         4'd4: return {6'b100000, f.rs, f.rt, f.imm};
         4'd5: return {6'b000001, f.rs, f.rt, f.imm};
         4'd6: return {6'b000010, f.target};
         4'd7: return {6'b000011, f.rs, 21'b0};
         4'd8: return {6'b000111, f.target};
         4'd9: return {6'b001111, f.rs, 21'b0};
         default: return 32'h0;
      endcase
   endfunction

   // Control decoder view of an opcode: {reg_write, branch, bne, jump, jr, jal}.
   function automatic logic [5:0] ctrl_decode(input logic [5:0] opc);
      case (opc)
         6'b000000: return 6'b100000;
         6'b100011: return 6'b100000;
         6'b101011: return 6'b000000;
         6'b000100: return 6'b010000;
         6'b100000: return 6'b011000;
         6'b000001: return 6'b100000;
         6'b000010: return 6'b000100;
         6'b000011: return 6'b000010;
         6'b000111: return 6'b100101;
         6'b001111: return 6'b100011;
         default:   return 6'b111111;
      endcase
   endfunction

   // Intended control signals for each op_sel.
   function automatic logic [5:0] ctrl_intended(input logic [3:0] op);
      case (op)
         4'd0: return 6'b100000;  // R: RegWrite
         4'd1: return 6'b100000;  // LW: RegWrite
         4'd2: return 6'b000000;  // SW
         4'd3: return 6'b010000;  // BEQ: Branch
         4'd4: return 6'b011000;  // BNE: Branch + bne
         4'd5: return 6'b100000;  // ADDI: RegWrite
         4'd6: return 6'b000100;  // J: Jump
         4'd7: return 6'b000010;  // JR: jr
         4'd8: return 6'b100101;  // JAL: RegWrite + Jump + jal
         4'd9: return 6'b100011;  // JALR: RegWrite + jr + jal
         default: return 6'b000000;
      endcase
   endfunction

   // One offered transaction: predicts what the encoder does with it.
   function automatic obs_t model_step(input fields_t f);
      obs_t e;
      e = '0;
      e.ready = (m_count < CAP);
      if (!e.ready) begin
         m_efull = 1'b1;
      end else if (f.op > 4'd9) begin
         m_einv = 1'b1;
      end else begin
         e.we    = 1'b1;
         e.addr  = ADDR_W'((int'(BASE) + m_count) % CAP);
         e.wdata = ref_word(f);
         m_count = m_count + 1;
      end
      e.cnt   = (ADDR_W+1)'(m_count);
      e.full  = (m_count == CAP);
      e.einv  = m_einv;
      e.efull = m_efull;
      return e;
   endfunction

   function automatic void model_reset();
      m_count = 0;
      m_einv  = 1'b0;
      m_efull = 1'b0;
   endfunction

   function automatic fields_t rand_fields(input logic [3:0] op);
      fields_t f;
      f.op     = op;
      f.rs     = 5'($urandom);
      f.rt     = 5'($urandom);
      f.rd     = 5'($urandom);
      f.shamt  = 5'($urandom);
      f.funct  = 6'($urandom);
      f.imm    = 16'($urandom);
      f.target = 26'($urandom);
      return f;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_fields(input fields_t f);
      bus.op_sel = f.op;
      bus.rs     = f.rs;
      bus.rt     = f.rt;
      bus.rd     = f.rd;
      bus.shamt  = f.shamt;
      bus.funct  = f.funct;
      bus.imm    = f.imm;
      bus.target = f.target;
   endtask

   // Offer fields for one cycle and record what the encoder does.
   task automatic drive_op(input fields_t f, output obs_t o);
      o = '0;
      @(negedge clk);
      o.ready = bus.in_ready;
      set_fields(f);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      o.we = bus.mem_we;
      if (bus.mem_we) begin
         o.addr  = bus.mem_addr;
         o.wdata = bus.mem_wdata;
      end
      @(negedge clk);
      o.we_after = bus.mem_we;
      o.cnt      = count;
      o.full     = full;
      o.einv     = err_invalid;
      o.efull    = err_full;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      obs_t o, e;
      @(negedge clk);
      o = '0;
      o.ready = bus.in_ready; o.we = bus.mem_we; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
      o.cnt = count; o.full = full; o.einv = err_invalid; o.efull = err_full;
      e = '0;
      e.ready = 1'b1; e.addr = BASE;
      n_checks++;
      if (o !== e) begin
         n_errors++;
         $display("FAIL reset_state: got %h required %h", o, e);
      end
      $display("txn reset: ready=%0b we=%0b addr=%0d count=%0d", o.ready, o.we, o.addr, o.cnt);
   endtask

   task automatic test_lw_directed();
      fields_t f;
      obs_t o, e;
      f = rand_fields(4'd1);
      f.rs = 5'd2; f.rt = 5'd3; f.imm = 16'h0010;
      e = model_step(f);
      drive_op(f, o);
      n_checks++;
      if (o !== e) begin
         n_errors++;
         $display("FAIL lw_txn: got %h required %h", o, e);
      end
      n_checks++;
      if (o.wdata !== 32'h8C430010) begin
         n_errors++;
         $display("FAIL lw_word: got %h required 8c430010", o.wdata);
      end
      $display("txn lw: addr=%0d wdata=%h count=%0d", o.addr, o.wdata, o.cnt);
   endtask

   task automatic test_back_to_back();
      fields_t fr, fj;
      obs_t e1, e2;
      fr = rand_fields(4'd0);
      fr.rs = 5'd1; fr.rt = 5'd2; fr.rd = 5'd3; fr.shamt = 5'd0; fr.funct = 6'h20;
      fj = rand_fields(4'd6);
      fj.target = 26'h40;
      e1 = model_step(fr);
      e2 = model_step(fj);
      @(negedge clk);
      set_fields(fr);
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_write1_hs: ready=%0b we=%0b required ready=0 we=1", bus.in_ready, bus.mem_we);
      end
      n_checks++;
      if (bus.mem_addr !== e1.addr || bus.mem_wdata !== 32'h00221820 || e1.wdata !== 32'h00221820) begin
         n_errors++;
         $display("FAIL b2b_write1: got %0d/%h required %0d/00221820", bus.mem_addr, bus.mem_wdata, e1.addr);
      end
      $display("txn b2b R: addr=%0d wdata=%h", bus.mem_addr, bus.mem_wdata);
      set_fields(fj);
      @(negedge clk);
      n_checks++;
      if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_gap: we=%0b ready=%0b required we=0 ready=1", bus.mem_we, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== e2.addr || bus.mem_wdata !== 32'h08000040) begin
         n_errors++;
         $display("FAIL b2b_write2: we=%0b %0d/%h required 1 %0d/08000040", bus.mem_we, bus.mem_addr, bus.mem_wdata, e2.addr);
      end
      $display("txn b2b J: addr=%0d wdata=%h", bus.mem_addr, bus.mem_wdata);
      @(negedge clk);
      n_checks++;
      if (count !== e2.cnt || bus.mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_count: count=%0d we=%0b required %0d 0", count, bus.mem_we, e2.cnt);
      end
   endtask

   task automatic test_invalid();
      fields_t f;
      obs_t o, e;
      f = rand_fields(4'd12);
      e = model_step(f);
      drive_op(f, o);
      n_checks++;
      if (o !== e) begin
         n_errors++;
         $display("FAIL invalid_op: got %h required %h", o, e);
      end
      $display("txn invalid: we=%0b err_invalid=%0b count=%0d", o.we, o.einv, o.cnt);
      f = rand_fields(4'($urandom_range(9, 0)));
      e = model_step(f);
      drive_op(f, o);
      n_checks++;
      if (o !== e) begin
         n_errors++;
         $display("FAIL after_invalid: got %h required %h", o, e);
      end
      $display("txn after invalid: op=%0d addr=%0d wdata=%h", f.op, o.addr, o.wdata);
   endtask

   task automatic test_clear_in_write();
      fields_t f;
      f = rand_fields(4'($urandom_range(9, 0)));
      @(negedge clk);
      set_fields(f);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.mem_we !== 1'b1) begin
         n_errors++;
         $display("FAIL clear_write_start: we=%0b required 1", bus.mem_we);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      n_checks++;
      if (bus.mem_we !== 1'b0 || count !== '0 || bus.mem_addr !== BASE || bus.mem_wdata !== 32'h0) begin
         n_errors++;
         $display("FAIL clear_abort: we=%0b count=%0d addr=%0d wdata=%h required 0 0 %0d 0", bus.mem_we, count, bus.mem_addr, bus.mem_wdata, BASE);
      end
      n_checks++;
      if (full !== 1'b0 || err_invalid !== 1'b0 || err_full !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL clear_flags: full=%0b einv=%0b efull=%0b ready=%0b required 0 0 0 1", full, err_invalid, err_full, bus.in_ready);
      end
      $display("txn clear in write: we=%0b count=%0d addr=%0d", bus.mem_we, count, bus.mem_addr);
   endtask

   task automatic test_random_fill();
      fields_t f;
      obs_t o, e;
      int guard;
      for (int round = 0; round < 3; round++) begin
         do_clear();
         guard = 0;
         while (m_count < CAP && guard < 100) begin
            if ($urandom_range(7, 0) == 0) f = rand_fields(4'($urandom_range(15, 10)));
            else f = rand_fields(4'($urandom_range(9, 0)));
            e = model_step(f);
            drive_op(f, o);
            guard++;
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL random_txn r%0d op=%0d: got %h required %h", round, f.op, o, e);
            end
            $display("txn random r%0d: op=%0d we=%0b addr=%0d wdata=%h count=%0d full=%0b", round, f.op, o.we, o.addr, o.wdata, o.cnt, o.full);
         end
         for (int k = 0; k < 2; k++) begin
            f = rand_fields(4'($urandom_range(9, 0)));
            e = model_step(f);
            drive_op(f, o);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL full_block r%0d: got %h required %h", round, o, e);
            end
            $display("txn while full: ready=%0b we=%0b err_full=%0b count=%0d", o.ready, o.we, o.efull, o.cnt);
         end
      end
   endtask

   task automatic test_roundtrip();
      fields_t f;
      obs_t o, e;
      logic [5:0] got_ctrl;
      do_clear();
      for (int op = 0; op < 10; op++) begin
         if (m_count == CAP) do_clear();
         f = rand_fields(4'(op));
         e = model_step(f);
         drive_op(f, o);
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL roundtrip_txn op=%0d: got %h required %h", op, o, e);
         end
         got_ctrl = ctrl_decode(o.wdata[31:26]);
         n_checks++;
         if (got_ctrl !== ctrl_intended(4'(op))) begin
            n_errors++;
            $display("FAIL roundtrip_ctrl op=%0d: got %b required %b", op, got_ctrl, ctrl_intended(4'(op)));
         end
         $display("txn roundtrip: op=%0d opcode=%b ctrl=%b", op, o.wdata[31:26], got_ctrl);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      set_fields('0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      test_reset();
      test_lw_directed();
      test_back_to_back();
      test_invalid();
      test_clear_in_write();
      test_random_fill();
      test_roundtrip();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
